// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle subtractor computing diff = A - B - bin
// (mod 2^WIDTH). It processes DIGIT bits per clock, LSB slice first, and
// carries the borrow between slices in a register.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits per cycle (1..WIDTH, must divide WIDTH)
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, accepted only when not busy (IDLE or DONE state)
//   A, B    minuend / subtrahend, sampled with an accepted start
//   bin     borrow-in, sampled with an accepted start
//   busy    high while slices are being processed
//   done    one-cycle pulse, result valid
//   diff    registered result, holds until the next completion
//   borrow  registered final borrow-out
//   zero    registered (diff == 0)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned K  = WIDTH / DIGIT;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_shift;
    logic             accept;

    // (DIGIT+1)-bit subtraction: the MSB of the result is the slice borrow-out.
    assign slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};

    // New slice enters the result shift register from the top.
    generate
        if (DIGIT == WIDTH) begin : g_single_slice
            assign res_shift = slice[DIGIT-1:0];
        end else begin : g_multi_slice
            assign res_shift = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_shift;
                brw_d = slice[DIGIT];
                cnt_d = cnt_q + 1'b1;
                // Output registers are loaded on the edge entering DONE so
                // that the result is already visible while done is high.
                if (cnt_q == CW'(K - 1)) begin
                    state_d  = DONE;
                    diff_d   = res_shift;
                    borrow_d = slice[DIGIT];
                    zero_d   = (res_shift == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = A;
            b_d     = B;
            brw_d   = bin;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule
